clock_set_ctrl: RTL
===================

# clock_set_ctrl

Mode and time-set controller for the digital clock/alarm. It consumes the one-cycle pulses produced by the debounced pushbutton blocks and runs a mode state machine: normal run, set clock hour/minute, set alarm hour/minute. It owns the alarm time registers and the alarm enable. It issues a one-cycle load to the timekeeping counter and a blink flag to the display driver.

## Interface
- TIMEOUT_TICKS, default 10: number of tick_1hz pulses with no button press before an edit mode abandons back to RUN.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tick_1hz  in  1  one-cycle pulse, once per second, from the clock divider.
- btn_mode  in  1  one-cycle debounced pulse; advance mode.
- btn_up  in  1  one-cycle pulse; increment the field being edited.
- btn_down  in  1  one-cycle pulse; decrement the field being edited.
- btn_ok  in  1  one-cycle pulse; commit the edit, or toggle the alarm in RUN.
- cur_hour  in  5  current hour from the timekeeper, 0..23.
- cur_min  in  6  current minute from the timekeeper, 0..59.
- mode  out  3  current state encoding.
- edit_hour  out  5  hour value under edit; also the clock load value.
- edit_min  out  6  minute value under edit; also the clock load value.
- time_load  out  1  one-cycle strobe; the timekeeper loads edit_hour/edit_min.
- alarm_hour  out  5  stored alarm hour.
- alarm_min  out  6  stored alarm minute.
- alarm_en  out  1  alarm armed.
- blink  out  1  display blink phase for the edited field; 0 in RUN.

## Operation
- States: RUN=0, SET_H=1, SET_M=2, AL_H=3, AL_M=4. Encodings 5..7 are illegal and recover to RUN on the next clock.
- Button priority when several pulses occur in one cycle: ok > mode > up/down. If up and down occur together, they cancel (no change).
- **RUN**
  - mode → SET_H; edit_hour/edit_min are captured from cur_hour/cur_min.
  - ok toggles alarm_en.
  - up/down are ignored.
- **SET_H**: up/down changes edit_hour modulo 24 (23+1→0, 0−1→23).
  - mode → SET_M.
  - ok → RUN with time_load=1.
- **SET_M**: up/down changes edit_min modulo 60 (59+1→0, 0−1→59).
  - mode → AL_H; the clock edit is discarded and edit regs are captured from alarm_hour/alarm_min.
  - ok → RUN with time_load=1.
- **AL_H / AL_M**: same wrap rules on edit_hour/edit_min.
  - AL_H mode → AL_M.
  - AL_M mode → RUN, edit discarded.
  - ok in either state → RUN; alarm_hour/alarm_min ← edit values and alarm_en ← 1. No time_load.
- **Timeout**
  - A counter clears on entry to any edit state and on any button pulse.
  - It increments on tick_1hz while in an edit state.
  - When it reaches TIMEOUT_TICKS, the state goes to RUN and the edit is discarded: no load, alarm regs unchanged.
  - A button pulse and tick_1hz in the same cycle: the button wins, and the counter becomes 0.
- **blink**
  - Set to 1 on entry to an edit state.
  - Toggles on each tick_1hz while editing.
  - Forced to 0 in RUN.

## Timing
- All outputs are registered. A button pulse sampled at edge N produces its effect visible after edge N.
- time_load is high for exactly one cycle, the cycle after the ok edge. edit_hour/edit_min hold the committed values during that cycle and stay stable until the next edit entry.
- Reset values, applied asynchronously on rst low:
  - state RUN, mode=0;
  - edit_hour=0, edit_min=0;
  - alarm_hour=0, alarm_min=0, alarm_en=0;
  - time_load=0, blink=0;
  - timeout counter=0.
- Reset during an edit abandons the edit. No time_load is issued during reset or on its release.
- Back-to-back pulses on consecutive cycles are each honoured.

## Structure
- The shared package holds:
  - the state encoding constants;
  - HOURS=24 and MINS=60;
  - field widths 5 and 6.
- One sub-module, edit_wrap_ctr, is natural: a parameterised modulo-N up/down counter with synchronous load, instantiated twice (hour, minute).

## Test plan
- Reset, then mode, up×3, ok from cur_hour=22/cur_min=15 → SET_H, edit_hour 23→0→1; one-cycle time_load with edit_hour=1, edit_min=15; state RUN.
- Minute wrap: in SET_M at edit_min=0, down → 59; up → 0.
- Alarm path: mode×3 → AL_H; up×7; mode; down×1; ok → alarm_hour=7, alarm_min=59 (from 0/0), alarm_en=1, no time_load. Then ok in RUN → alarm_en=0.
- Timeout: with TIMEOUT_TICKS=3, enter SET_H and press up once, then send 3 ticks with no buttons → RUN, no time_load, blink 1→0→1 then 0. Also: a tick coincident with a button does not advance the counter.
- Simultaneous events: ok+mode in SET_M → commit load, RUN. up+down together → edit unchanged.
- Assert rst mid-edit in AL_M → all outputs at reset values immediately; the alarm regs are cleared.

Source files
------------

// File: rtl/clock_set_ctrl_pkg.sv
// Shared definitions for the clock/alarm mode and time-set controller.
package clock_set_ctrl_pkg;

   localparam int HOURS  = 24;
   localparam int MINS   = 60;
   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;

   typedef enum logic [2:0] {
      ST_RUN   = 3'd0,
      ST_SET_H = 3'd1,
      ST_SET_M = 3'd2,
      ST_AL_H  = 3'd3,
      ST_AL_M  = 3'd4
   } state_e;

endpackage

// File: rtl/clock_set_ctrl_edit_wrap_ctr.sv
// Modulo-N up/down counter with synchronous load; load beats up/down,
// and up together with down leaves the value unchanged.
module edit_wrap_ctr #(
   parameter int N = 24,
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_up,
   input  logic         i_dn,
   output logic [W-1:0] o_val
);

   logic [W-1:0] r_val;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_val <= '0;
      else if (i_load)
         r_val <= i_load_val;
      else if (i_up && !i_dn)
         r_val <= (r_val == W'(N-1)) ? '0 : r_val + 1'b1;
      else if (i_dn && !i_up)
         r_val <= (r_val == '0) ? W'(N-1) : r_val - 1'b1;
   end

   assign o_val = r_val;

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode FSM for the digital clock: run, set clock h/m, set alarm h/m.
// Owns the alarm registers and drives the timekeeper load strobe and blink.
module clock_set_ctrl
   import clock_set_ctrl_pkg::*;
#(
   parameter int TIMEOUT_TICKS = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick_1hz,
   input  logic              btn_mode,
   input  logic              btn_up,
   input  logic              btn_down,
   input  logic              btn_ok,
   input  logic [HOUR_W-1:0] cur_hour,
   input  logic [MIN_W-1:0]  cur_min,
   output logic [2:0]        mode,
   output logic [HOUR_W-1:0] edit_hour,
   output logic [MIN_W-1:0]  edit_min,
   output logic              time_load,
   output logic [HOUR_W-1:0] alarm_hour,
   output logic [MIN_W-1:0]  alarm_min,
   output logic              alarm_en,
   output logic              blink
);

   localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

   state_e            r_state, w_next;
   logic [TO_W-1:0]   r_to_cnt;
   logic              r_time_load, r_blink, r_alarm_en;
   logic [HOUR_W-1:0] r_alarm_hour;
   logic [MIN_W-1:0]  r_alarm_min;

   logic              w_any_btn, w_up, w_dn, w_timeout;
   logic              w_ld_cur, w_ld_al, w_h_en, w_m_en;
   logic              w_load_nxt, w_commit_al, w_toggle_en;
   logic [TO_W-1:0]   w_to_inc;
   logic [HOUR_W-1:0] w_h_ld_val;
   logic [MIN_W-1:0]  w_m_ld_val;

   assign w_any_btn = btn_mode | btn_up | btn_down | btn_ok;
   assign w_up      = btn_up & ~btn_down;
   assign w_dn      = btn_down & ~btn_up;
   assign w_to_inc  = r_to_cnt + 1'b1;
   // Any button restarts the idle count, so a coincident tick cannot time out.
   assign w_timeout = (r_state != ST_RUN) && tick_1hz && !w_any_btn &&
                      (w_to_inc == TO_W'(TIMEOUT_TICKS));

   always_comb begin
      w_next      = r_state;
      w_ld_cur    = 1'b0;
      w_ld_al     = 1'b0;
      w_h_en      = 1'b0;
      w_m_en      = 1'b0;
      w_load_nxt  = 1'b0;
      w_commit_al = 1'b0;
      w_toggle_en = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (btn_ok)
               w_toggle_en = 1'b1;
            else if (btn_mode) begin
               w_next   = ST_SET_H;
               w_ld_cur = 1'b1;
            end
         end
         ST_SET_H: begin
            if (btn_ok) begin
               w_next     = ST_RUN;
               w_load_nxt = 1'b1;
            end else if (btn_mode)
               w_next = ST_SET_M;
            else
               w_h_en = 1'b1;
         end
         ST_SET_M: begin
            if (btn_ok) begin
               w_next     = ST_RUN;
               w_load_nxt = 1'b1;
            end else if (btn_mode) begin
               w_next  = ST_AL_H;
               w_ld_al = 1'b1;
            end else
               w_m_en = 1'b1;
         end
         ST_AL_H: begin
            if (btn_ok) begin
               w_next      = ST_RUN;
               w_commit_al = 1'b1;
            end else if (btn_mode)
               w_next = ST_AL_M;
            else
               w_h_en = 1'b1;
         end
         ST_AL_M: begin
            if (btn_ok) begin
               w_next      = ST_RUN;
               w_commit_al = 1'b1;
            end else if (btn_mode)
               w_next = ST_RUN;
            else
               w_m_en = 1'b1;
         end
         default: w_next = ST_RUN;
      endcase
      if (w_timeout)
         w_next = ST_RUN;
   end

   assign w_h_ld_val = w_ld_al ? r_alarm_hour : cur_hour;
   assign w_m_ld_val = w_ld_al ? r_alarm_min  : cur_min;

   edit_wrap_ctr #(.N(HOURS), .W(HOUR_W)) u_hour (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_ld_cur | w_ld_al),
      .i_load_val (w_h_ld_val),
      .i_up       (w_h_en & w_up),
      .i_dn       (w_h_en & w_dn),
      .o_val      (edit_hour)
   );

   edit_wrap_ctr #(.N(MINS), .W(MIN_W)) u_min (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_ld_cur | w_ld_al),
      .i_load_val (w_m_ld_val),
      .i_up       (w_m_en & w_up),
      .i_dn       (w_m_en & w_dn),
      .o_val      (edit_min)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_RUN;
         r_to_cnt     <= '0;
         r_time_load  <= 1'b0;
         r_blink      <= 1'b0;
         r_alarm_en   <= 1'b0;
         r_alarm_hour <= '0;
         r_alarm_min  <= '0;
      end else begin
         r_state     <= w_next;
         r_time_load <= w_load_nxt;

         if (w_next == ST_RUN || w_any_btn || w_next != r_state)
            r_to_cnt <= '0;
         else if (tick_1hz)
            r_to_cnt <= w_to_inc;

         // Blink restarts high on each field entry so the new field shows at once.
         if (w_next == ST_RUN)
            r_blink <= 1'b0;
         else if (w_next != r_state)
            r_blink <= 1'b1;
         else if (tick_1hz)
            r_blink <= ~r_blink;

         if (w_commit_al) begin
            r_alarm_hour <= edit_hour;
            r_alarm_min  <= edit_min;
            r_alarm_en   <= 1'b1;
         end else if (w_toggle_en)
            r_alarm_en <= ~r_alarm_en;
      end
   end

   assign mode       = r_state;
   assign time_load  = r_time_load;
   assign blink      = r_blink;
   assign alarm_en   = r_alarm_en;
   assign alarm_hour = r_alarm_hour;
   assign alarm_min  = r_alarm_min;

endmodule
